// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: score entry layout,
// FSM states and the note-to-frequency_select mapping.
package melody_pkg;

    typedef struct packed {
        logic [5:0] note;
        logic [7:0] duration;
    } score_entry_t;

    localparam logic [5:0]  REST_CODE = 6'd63;
    localparam logic [31:0] SILENCE   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    // Rests and out-of-range notes both map to silence.
    function automatic logic [31:0] note_freq(input logic [5:0] note, input int note_number);
        if (note == REST_CODE || int'(note) >= note_number) return SILENCE;
        return {26'd0, note};
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a player controller and the melody sequencer.
interface melody_sequencer_if #(
    parameter int SONG_LENGTH = 64
);
    localparam int PW = (SONG_LENGTH > 1) ? $clog2(SONG_LENGTH) : 1;

    logic          start;
    logic          stop;
    logic          pause;
    logic          loop_enable;
    logic [31:0]   frequency_select;
    logic          playing;
    logic [PW-1:0] position;
    logic          done;

    modport master (
        output start, stop, pause, loop_enable,
        input  frequency_select, playing, position, done
    );

    modport slave (
        input  start, stop, pause, loop_enable,
        output frequency_select, playing, position, done
    );

endinterface

// File: rtl/melody_score_rom.sv
// Combinational score table: position -> {note, duration}. Every table ends
// with a duration==0 entry; unlisted positions also read as end of song.
module melody_score_rom
    import melody_pkg::*;
#(
    parameter int SONG_LENGTH    = 64,
    parameter bit USE_TEST_SCORE = 1'b0,
    localparam int PW = (SONG_LENGTH > 1) ? $clog2(SONG_LENGTH) : 1
) (
    input  logic [PW-1:0] position,
    output score_entry_t  entry
);

    always_comb begin
        entry = '{REST_CODE, 8'd0};
        if (USE_TEST_SCORE) begin
            case (int'(position))
                0:       entry = '{6'd9,     8'd3};
                1:       entry = '{REST_CODE, 8'd2};
                2:       entry = '{6'd0,     8'd1};
                default: entry = '{REST_CODE, 8'd0};
            endcase
        end else begin
            // Twinkle Twinkle in the C4 octave; 4 ticks per quarter, 8 per half.
            case (int'(position))
                0, 1:    entry = '{6'd0, 8'd4};
                2, 3:    entry = '{6'd7, 8'd4};
                4, 5:    entry = '{6'd9, 8'd4};
                6:       entry = '{6'd7, 8'd8};
                7, 8:    entry = '{6'd5, 8'd4};
                9, 10:   entry = '{6'd4, 8'd4};
                11, 12:  entry = '{6'd2, 8'd4};
                13:      entry = '{6'd0, 8'd8};
                default: entry = '{REST_CODE, 8'd0};
            endcase
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the score table at a fixed tempo and drives the note index
// (or all-ones for silence) to the downstream square-wave generator.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int TICK_HZ         = 16,
    parameter int SONG_LENGTH     = 64,
    parameter int NOTE_NUMBER     = 36,
    parameter bit USE_TEST_SCORE  = 1'b0
) (
    input logic               clock,
    input logic               reset,
    melody_sequencer_if.slave bus
);

    localparam int CPT = CLOCK_FREQUENCY / TICK_HZ;
    localparam int CW  = (CPT > 1) ? $clog2(CPT) : 1;
    localparam int PW  = (SONG_LENGTH > 1) ? $clog2(SONG_LENGTH) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CPT - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(SONG_LENGTH - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    remaining, rem_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic [31:0]   freq, freq_nxt;
    logic          done_q, done_nxt;
    logic          counting, tick, song_end;
    logic [31:0]   entry_freq;
    score_entry_t  entry;

    melody_score_rom #(
        .SONG_LENGTH   (SONG_LENGTH),
        .USE_TEST_SCORE(USE_TEST_SCORE)
    ) u_rom (
        .position(pos),
        .entry   (entry)
    );

    // Position is frozen through PLAY/GAP, so the table output stays valid
    // as the held note and restores it after a pause.
    assign entry_freq = note_freq(entry.note, NOTE_NUMBER);
    assign counting   = (state == PLAY || state == GAP) && !bus.pause;
    assign tick       = counting && (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = remaining;
        pos_nxt   = pos;
        freq_nxt  = freq;
        done_nxt  = 1'b0;
        song_end  = 1'b0;
        if (counting) cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (bus.stop) begin
            state_nxt = IDLE;
            pos_nxt   = '0;
            cnt_nxt   = '0;
            rem_nxt   = '0;
            freq_nxt  = SILENCE;
        end else if (bus.start) begin
            state_nxt = LOAD;
            pos_nxt   = '0;
            cnt_nxt   = '0;
            freq_nxt  = SILENCE;
        end else begin
            unique case (state)
                IDLE, DONE: freq_nxt = SILENCE;
                LOAD: begin
                    cnt_nxt = '0;
                    if (entry.duration == 8'd0) begin
                        song_end = 1'b1;
                    end else begin
                        rem_nxt = entry.duration;
                        // The last tick of every duration is the silent gap.
                        if (entry.duration == 8'd1) begin
                            state_nxt = GAP;
                            freq_nxt  = SILENCE;
                        end else begin
                            state_nxt = PLAY;
                            freq_nxt  = entry_freq;
                        end
                    end
                end
                PLAY: begin
                    freq_nxt = bus.pause ? SILENCE : entry_freq;
                    if (tick) begin
                        rem_nxt = remaining - 8'd1;
                        if (remaining == 8'd2) begin
                            state_nxt = GAP;
                            freq_nxt  = SILENCE;
                        end
                    end
                end
                GAP: begin
                    freq_nxt = SILENCE;
                    if (tick) begin
                        rem_nxt = remaining - 8'd1;
                        if (pos == POS_LAST) begin
                            song_end = 1'b1;
                        end else begin
                            pos_nxt   = pos + 1'b1;
                            state_nxt = LOAD;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (song_end) begin
                freq_nxt = SILENCE;
                if (bus.loop_enable) begin
                    pos_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            pos       <= '0;
            freq      <= SILENCE;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= rem_nxt;
            pos       <= pos_nxt;
            freq      <= freq_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.frequency_select = freq;
    assign bus.playing          = (state == LOAD) || (state == PLAY) || (state == GAP);
    assign bus.position         = pos;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer on the 4-entry test score at 10 cycles per tick,
// checked cycle by cycle against a timeline model plus directed timing checks.
module tb_melody_sequencer;
    import melody_pkg::*;

    localparam int SL = 64;
    localparam int T  = 10;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    melody_sequencer_if #(.SONG_LENGTH(SL)) bus();

    melody_sequencer #(
        .CLOCK_FREQUENCY(100),
        .TICK_HZ        (10),
        .SONG_LENGTH    (SL),
        .NOTE_NUMBER    (36),
        .USE_TEST_SCORE (1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: each entry occupies dur*T unpaused cycles after its load cycle;
    // it sounds for the first (dur-1)*T of them.
    int s_note[4] = '{9, 63, 0, 0};
    int s_dur[4]  = '{3, 2, 1, 0};
    int m_mode = M_IDLE, m_pos = 0, m_el = 0;
    logic [31:0] m_freq = SILENCE;
    logic m_done = 1'b0;

    function automatic int dur_at(input int p);
        return (p < 4) ? s_dur[p] : 0;
    endfunction

    function automatic logic [31:0] nfreq(input int p);
        if (p >= 4 || s_note[p] >= 36) return SILENCE;
        return 32'(s_note[p]);
    endfunction

    function automatic logic [39:0] obs();
        return {bus.frequency_select, bus.playing, bus.position, bus.done};
    endfunction

    function automatic logic [39:0] expv();
        logic pl;
        pl = (m_mode == M_LOAD) || (m_mode == M_RUN);
        return {m_freq, pl, 6'(m_pos), m_done};
    endfunction

    task automatic end_song(input logic lp);
        m_freq = SILENCE;
        if (lp) begin
            m_pos  = 0;
            m_mode = M_LOAD;
        end else begin
            m_mode = M_DONE;
            m_done = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic sp, input logic pa, input logic lp);
        int d;
        reset = r;
        bus.start = st;
        bus.stop = sp;
        bus.pause = pa;
        bus.loop_enable = lp;
        @(posedge clock);
        m_done = 1'b0;
        if (r || sp) begin
            m_mode = M_IDLE;
            m_pos  = 0;
            m_el   = 0;
            m_freq = SILENCE;
        end else if (st) begin
            m_mode = M_LOAD;
            m_pos  = 0;
            m_freq = SILENCE;
        end else begin
            d = dur_at(m_pos);
            case (m_mode)
                M_LOAD: begin
                    if (d == 0) end_song(lp);
                    else begin
                        m_mode = M_RUN;
                        m_el   = 0;
                        m_freq = (d > 1) ? nfreq(m_pos) : SILENCE;
                    end
                end
                M_RUN: begin
                    if (pa) m_freq = SILENCE;
                    else begin
                        m_el++;
                        if (m_el == d * T) begin
                            if (m_pos == SL - 1) end_song(lp);
                            else begin
                                m_pos++;
                                m_mode = M_LOAD;
                                m_freq = SILENCE;
                            end
                        end else begin
                            m_freq = (m_el < (d - 1) * T) ? nfreq(m_pos) : SILENCE;
                        end
                    end
                end
                default: m_freq = SILENCE;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if (bus.frequency_select !== SILENCE) begin
            failures++; $display("FAIL reset_freq got=%h want=%h", bus.frequency_select, SILENCE);
        end
        checks++;
        if ({bus.playing, bus.position, bus.done} !== 8'd0) begin
            failures++; $display("FAIL reset_status got=%b want=0", {bus.playing, bus.position, bus.done});
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== expv()) begin
            failures++; $display("FAIL reset_idle got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_basic();
        int sound = 0, first = -1, dones = 0, done_at = -1;
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 80; c++) begin
            step(0, c == 1, 0, 0, 0);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL basic c=%0d got=%h want=%h", c, obs(), expv());
            end
            if (bus.frequency_select == 32'd9) begin
                sound++;
                if (first < 0) first = c;
            end
            if (bus.done) begin dones++; done_at = c; end
        end
        checks++;
        if (first != 2) begin failures++; $display("FAIL basic_first got=%0d want=2", first); end
        checks++;
        if (sound != 20) begin failures++; $display("FAIL basic_sound got=%0d want=20", sound); end
        checks++;
        if (dones != 1 || done_at != 65) begin
            failures++; $display("FAIL basic_done got=%0d@%0d want=1@65", dones, done_at);
        end
        checks++;
        if (bus.playing !== 1'b0) begin failures++; $display("FAIL basic_playing got=%b want=0", bus.playing); end
    endtask

    task automatic test_loop();
        int rises = 0, dones = 0;
        logic [31:0] prev = SILENCE;
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 200; c++) begin
            step(0, c == 1, 0, 0, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL loop c=%0d got=%h want=%h", c, obs(), expv());
            end
            if (bus.frequency_select == 32'd9 && prev != 32'd9) rises++;
            if (bus.done) dones++;
            if (c == 65) begin
                checks++;
                if (bus.position !== 6'd0 || bus.playing !== 1'b1) begin
                    failures++; $display("FAIL loop_wrap got=pos%0d/play%b want=pos0/play1", bus.position, bus.playing);
                end
            end
            prev = bus.frequency_select;
        end
        checks++;
        if (rises != 4) begin failures++; $display("FAIL loop_rises got=%0d want=4", rises); end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL loop_done got=%0d want=0", dones); end
    endtask

    task automatic test_pause();
        int sound = 0;
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 80; c++) begin
            step(0, c == 1, 0, c >= 8 && c <= 32, 0);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL pause c=%0d got=%h want=%h", c, obs(), expv());
            end
            if (bus.frequency_select == 32'd9) sound++;
            if (c == 20) begin
                checks++;
                if (bus.frequency_select !== SILENCE || bus.playing !== 1'b1) begin
                    failures++; $display("FAIL pause_silent got=%h/%b want=%h/1", bus.frequency_select, bus.playing, SILENCE);
                end
            end
        end
        checks++;
        if (sound != 20) begin failures++; $display("FAIL pause_sound got=%0d want=20", sound); end
    endtask

    task automatic test_stop();
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            step(0, c == 1, c == 12, 0, 0);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL stop c=%0d got=%h want=%h", c, obs(), expv());
            end
        end
        checks++;
        if ({bus.frequency_select, bus.playing, bus.position} !== {SILENCE, 7'd0}) begin
            failures++; $display("FAIL stop_idle got=%h/%b/%0d want=%h/0/0", bus.frequency_select, bus.playing, bus.position, SILENCE);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        checks++;
        if (bus.playing !== 1'b0 || bus.frequency_select !== SILENCE) begin
            failures++; $display("FAIL stop_start got=%b/%h want=0/%h", bus.playing, bus.frequency_select, SILENCE);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== expv()) begin failures++; $display("FAIL stop_after got=%h want=%h", obs(), expv()); end
    endtask

    task automatic test_restart_gap();
        int sound = 0, first = -1;
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 80; c++) begin
            step(0, c == 1 || c == 48, 0, 0, 0);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL restart c=%0d got=%h want=%h", c, obs(), expv());
            end
            if (c == 47) begin
                checks++;
                if (bus.position !== 6'd1 || bus.frequency_select !== SILENCE) begin
                    failures++; $display("FAIL restart_gap got=pos%0d/%h want=pos1/%h", bus.position, bus.frequency_select, SILENCE);
                end
            end
            if (c == 48) begin
                checks++;
                if (bus.position !== 6'd0 || bus.playing !== 1'b1) begin
                    failures++; $display("FAIL restart_load got=pos%0d/play%b want=pos0/play1", bus.position, bus.playing);
                end
            end
            if (c >= 48 && bus.frequency_select == 32'd9) begin
                sound++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (first != 49 || sound != 20) begin
            failures++; $display("FAIL restart_note got=%0d@%0d want=20@49", sound, first);
        end
    endtask

    task automatic test_reset_mid();
        int sound = 0, dones = 0;
        step(0, 0, 1, 0, 0);
        for (int c = 1; c <= 95; c++) begin
            step(c == 15, c == 1 || c == 16, 0, 0, 0);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL rstmid c=%0d got=%h want=%h", c, obs(), expv());
            end
            if (c == 15) begin
                checks++;
                if ({bus.frequency_select, bus.playing, bus.position, bus.done} !== {SILENCE, 8'd0}) begin
                    failures++; $display("FAIL rstmid_vals got=%h want=%h", obs(), {SILENCE, 8'd0});
                end
            end
            if (c > 15 && bus.frequency_select == 32'd9) sound++;
            if (bus.done) dones++;
        end
        checks++;
        if (sound != 20 || dones != 1) begin
            failures++; $display("FAIL rstmid_replay got=%0d/%0d want=20/1", sound, dones);
        end
    endtask

    task automatic test_random();
        logic pa = 1'b0, lp = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0) pa = ~pa;
            if ($urandom_range(0, 99) == 0) lp = ~lp;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 149) == 0, pa, lp);
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL random c=%0d got=%h want=%h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.loop_enable = 1'b0;
        test_reset();
        test_basic();
        test_loop();
        test_pause();
        test_stop();
        test_restart_gap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
